pattern_random2: RTL

//  Parametrised random-pixel pattern generator for a DISP_ROWS x DISP_COLUMNS grid of MAX7219 8x8 modules.

---
 rtl/max7219_types.sv | 36 +++
 rtl/lfsr_galois.sv | 63 ++++++
 rtl/pattern_random2.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/max7219_types.sv
`default_nettype none
// max7219_types: MAX7219 word fields and pattern op modes shared by the pattern generators.
package max7219_types;

  localparam logic [3:0] HDR       = 4'h0;
  localparam logic [3:0] REG_ROW_0 = 4'h1;
  localparam logic [3:0] REG_ROW_1 = 4'h2;
  localparam logic [3:0] REG_ROW_2 = 4'h3;
  localparam logic [3:0] REG_ROW_3 = 4'h4;
  localparam logic [3:0] REG_ROW_4 = 4'h5;
  localparam logic [3:0] REG_ROW_5 = 4'h6;
  localparam logic [3:0] REG_ROW_6 = 4'h7;
  localparam logic [3:0] REG_ROW_7 = 4'h8;

  typedef enum logic [1:0] {
    PAT_TOGGLE = 2'd0,
    PAT_SET    = 2'd1,
    PAT_CLEAR  = 2'd2,
    PAT_HOLD   = 2'd3
  } pattern_mode_t;

  function automatic logic [3:0] reg_row(input int k);
    case (k)
      0:       return REG_ROW_0;
      1:       return REG_ROW_1;
      2:       return REG_ROW_2;
      3:       return REG_ROW_3;
      4:       return REG_ROW_4;
      5:       return REG_ROW_5;
      6:       return REG_ROW_6;
      default: return REG_ROW_7;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_galois.sv
`default_nettype none
// lfsr_galois: right-shifting maximal-length Galois LFSR, negedge clocked, widths 8..32.
module lfsr_galois #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Step,
  output logic [WIDTH-1:0] o_Value
);

  function automatic logic [31:0] taps_for(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [31:0]      TAPS_ALL = taps_for(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (i_Step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  always_ff @(negedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) value_q <= SEED;
    else          value_q <= value_d;
  end

  assign o_Value = value_q;

endmodule
`default_nettype wire

// File: rtl/pattern_random2.sv
`default_nettype none
// pattern_random2: LFSR-addressed random pixel ops on a MAX7219 grid framebuffer, frame paced.
// Define PATTERN_RANDOM2_DOUBLE_BUFFER_EN to drive the stream from a per-frame shadow copy.
module pattern_random2
  import max7219_types::*;
#(
  parameter int DISP_ROWS        = 1,
  parameter int DISP_COLUMNS     = 1,
  parameter int CLK_FREQ_HZ      = 1,
  parameter int FRAME_RATE_HZ    = 10,
  parameter int PIXELS_PER_FRAME = 0,
  parameter int LFSR_SEED        = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic [1:0] i_Mode,
  output logic       o_Valid,
  output logic       o_Busy,
  output logic       o_Frame_Done,
  output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream
);

  localparam int FB_HEIGHT   = 8 * DISP_ROWS;
  localparam int FB_WIDTH    = 8 * DISP_COLUMNS;
  localparam int YW          = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam int XW          = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int LW          = (YW + XW + 3 > 8) ? (YW + XW + 3) : 8;
  localparam int DELAY_LIMIT = (CLK_FREQ_HZ / FRAME_RATE_HZ > 1) ? (CLK_FREQ_HZ / FRAME_RATE_HZ) : 1;
  localparam int TARGET      = (PIXELS_PER_FRAME == 0) ? (FB_HEIGHT * FB_WIDTH) : PIXELS_PER_FRAME;
  localparam int FCW         = $clog2(TARGET + 1);
  localparam int DCW         = $clog2(DELAY_LIMIT + 1);

  localparam logic [LW-1:0]  SEED_RAW  = LW'(LFSR_SEED);
  localparam logic [LW-1:0]  SEED      = (SEED_RAW == '0) ? LW'(1) : SEED_RAW;
  localparam logic [YW:0]    FB_H_L    = (YW + 1)'(FB_HEIGHT);
  localparam logic [XW:0]    FB_W_L    = (XW + 1)'(FB_WIDTH);
  localparam logic [YW-1:0]  ROW_LAST  = YW'(FB_HEIGHT - 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(TARGET - 1);
  localparam logic [DCW-1:0] DLIM      = DCW'(DELAY_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DELAY  = 2'd3
  } state_t;

  state_t                             state_q, state_d;
  logic [YW-1:0]                      row_q, row_d;
  logic [FCW-1:0]                     fcnt_q, fcnt_d;
  logic [DCW-1:0]                     dcnt_q, dcnt_d;
  pattern_mode_t                      mode_q, mode_d;
  logic                               valid_q, valid_d;
  logic                               done_q, done_d;
  logic [FB_HEIGHT-1:0][FB_WIDTH-1:0] fb_q, fb_d;
  logic [FB_HEIGHT-1:0][FB_WIDTH-1:0] disp;
  logic                               copy_shadow;

  logic          lfsr_step;
  logic [LW-1:0] lfsr_value;
  logic [YW-1:0] pix_y;
  logic [XW-1:0] pix_x;
  logic          pix_hit;

  lfsr_galois #(
    .WIDTH (LW),
    .SEED  (SEED)
  ) u_lfsr (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Step  (lfsr_step),
    .o_Value (lfsr_value)
  );

  assign pix_y   = lfsr_value[YW+XW-1:XW];
  assign pix_x   = lfsr_value[XW-1:0];
  assign pix_hit = ({1'b0, pix_y} < FB_H_L) && ({1'b0, pix_x} < FB_W_L);

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_value[LW-1:YW+XW];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    fcnt_d      = fcnt_q;
    dcnt_d      = dcnt_q;
    mode_d      = mode_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    fb_d        = fb_q;
    lfsr_step   = 1'b0;
    copy_shadow = 1'b0;

    case (state_q)
      ST_IDLE: begin
        row_d   = '0;
        state_d = ST_CLEAR;
      end

      ST_CLEAR: begin
        fb_d[row_q] = '0;
        row_d       = row_q + 1'b1;
        if (row_q == ROW_LAST) begin
          valid_d     = 1'b1;
          copy_shadow = 1'b1;
          fcnt_d      = '0;
          if (i_Enable) begin
            state_d = ST_UPDATE;
            mode_d  = pattern_mode_t'(i_Mode);
          end else begin
            // Enter DELAY already expired so a later enable starts a frame at once.
            state_d = ST_DELAY;
            dcnt_d  = DLIM;
          end
        end
      end

      ST_UPDATE: begin
        lfsr_step = 1'b1;
        if (pix_hit) begin
          case (mode_q)
            PAT_TOGGLE: fb_d[pix_y][pix_x] = ~fb_q[pix_y][pix_x];
            PAT_SET:    fb_d[pix_y][pix_x] = 1'b1;
            PAT_CLEAR:  fb_d[pix_y][pix_x] = 1'b0;
            default:    ;
          endcase
          if (fcnt_q == FCNT_LAST) begin
            fcnt_d      = '0;
            dcnt_d      = '0;
            done_d      = 1'b1;
            copy_shadow = 1'b1;
            state_d     = ST_DELAY;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end

      ST_DELAY: begin
        if (dcnt_q == DLIM) begin
          if (i_Enable) begin
            state_d = ST_UPDATE;
            mode_d  = pattern_mode_t'(i_Mode);
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      mode_q  <= PAT_TOGGLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Pixel storage has no reset: CLEAR wipes it after every reset release.
  always_ff @(negedge i_Clk) begin
    fb_q <= fb_d;
  end

`ifdef PATTERN_RANDOM2_DOUBLE_BUFFER_EN
  logic [FB_HEIGHT-1:0][FB_WIDTH-1:0] shadow_q;

  always_ff @(negedge i_Clk) begin
    if (copy_shadow) shadow_q <= fb_d;
  end

  assign disp = shadow_q;
`else
  logic unused_copy;
  assign unused_copy = copy_shadow;
  assign disp        = fb_q;
`endif

  for (genvar k = 0; k < 8; k++) begin : g_digit
    for (genvar r = 0; r < DISP_ROWS; r++) begin : g_row
      for (genvar c = 0; c < DISP_COLUMNS; c++) begin : g_col
        assign o_MAX7219_DataStream[k][r][c] = {HDR, reg_row(k), disp[r*8+k][c*8 +: 8]};
      end
    end
  end

  assign o_Valid      = valid_q;
  assign o_Busy       = (state_q == ST_CLEAR) || (state_q == ST_UPDATE);
  assign o_Frame_Done = done_q;

endmodule
`default_nettype wire
